fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits; SHALL match the FIFO's DSIZE.
REQ-002 Parameter RD_LAT, default 2, cycles from a pop to its word appearing on rdata; legal range 1..3.
REQ-003 Parameter BDEPTH, default 4, output buffer entries; power of two; SHALL satisfy BDEPTH >= RD_LAT+2.
REQ-004 rclk  input  1  sole clock; all state on its rising edge.
REQ-005 rrst  input  1  reset, asynchronous assert, active-high.
REQ-006 rempty  input  1  FIFO read-side empty flag, registered on rclk.
REQ-007 rdata  input  DSIZE  FIFO read data, valid RD_LAT cycles after the popping cycle.
REQ-008 rinc  output  1  pop request to the FIFO.
REQ-009 m_data  output  DSIZE  stream data to the consumer.
REQ-010 m_valid  output  1  m_data holds a valid word.
REQ-011 m_ready  input  1  consumer accepts the word this cycle.
REQ-012 rcount  output  16  count of words delivered on the stream.

Function
REQ-013 Pop: rinc SHALL be high in a cycle iff rempty==0, rrst==0 and credit>0, where credit = BDEPTH - occ - inflight, computed from registered values only.
REQ-014 occ: number of words held in the output buffer; inflight: number of pops not yet captured (0..RD_LAT).
REQ-015 Pop tracking: an RD_LAT-bit shift register; bit 0 loads rinc each cycle; when the bit leaving stage RD_LAT-1 is 1, rdata SHALL be written to buf[wptr] on that edge and wptr incremented modulo BDEPTH.
REQ-016 Latency: rinc high in cycle 0 -> word on rdata in cycle RD_LAT -> m_valid high with that word from cycle RD_LAT+1.
REQ-017 m_valid SHALL equal (occ != 0); m_data SHALL equal buf[rptr].
REQ-018 Handshake: on m_valid & m_ready, rptr increments modulo BDEPTH and rcount increments by 1, wrapping 16'hFFFF -> 0.
REQ-019 While m_valid & ~m_ready, m_data and m_valid SHALL hold stable.
REQ-020 Simultaneous capture and handshake in one cycle: occ unchanged; both pointers advance.
REQ-021 Credit freed by a handshake SHALL be usable from the next cycle, not the same cycle.
REQ-022 Buffer overflow SHALL be structurally impossible (occ+inflight <= BDEPTH always); the bench asserts it.
REQ-023 Throughput: with rempty==0 and m_ready==1 continuously, one word per cycle SHALL be delivered in steady state.
REQ-024 Words SHALL be delivered in pop order, with no loss or duplication.
REQ-025 rempty rising while pops are in flight SHALL NOT cancel them; the in-flight words are still captured.

Reset
REQ-026 While rrst is high: rinc=0, m_valid=0, rcount=0, occ=0, wptr=rptr=0, shift register cleared; m_data is don't-care.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; the FIFO read side is reset in the same domain at the same time.
REQ-028 First rinc SHALL NOT occur earlier than the first rising edge after rrst deasserts.

Verification
REQ-029 Single word: rempty falls in cycle 0, m_ready=1, rdata=8'hA5 in cycle 2 -> rinc high in cycle 0 only; m_valid with m_data=8'hA5 in cycle 3; rcount=1.
REQ-030 Streaming: 32 words 0..31 available, m_ready=1 -> rinc high 32 consecutive cycles; words 0..31 out in order on consecutive cycles from cycle 3; rcount=32.
REQ-031 Backpressure: m_ready=0, FIFO holding 10 words -> exactly 4 pops; m_valid high with word 0 stable; rinc stays 0. Then m_ready=1 -> all 10 words delivered in order.
REQ-032 Empty mid-stream: rempty rises after 3 pops -> exactly 3 words delivered; m_valid drops after the third; no further rinc.
REQ-033 Reset mid-stream: rrst pulses with occ=2 and inflight=2 -> m_valid=0 and rinc=0 immediately (asynchronous); rcount=0; no stale word delivered after release.
REQ-034 Random: random rempty and m_ready over 10k cycles -> scoreboard matches in order; occ+inflight <= 4 every cycle; rcount equals handshake count mod 2^16.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops a latency-RD_LAT FIFO into a small skid buffer and
// presents the words as a valid/ready stream, never popping more than it can hold.
module fifo_rd_stream #(
   parameter int DSIZE  = 8,
   parameter int RD_LAT = 2,
   parameter int BDEPTH = 4
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      rcount
);

   localparam int AW = $clog2(BDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(BDEPTH);

   logic [RD_LAT-1:0] vld_pipe;
   logic [DSIZE-1:0]  mem [BDEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [CW-1:0]     occ, inflight, credit;
   logic              cap, hs;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
   end

   // Credit counts every slot a word could still land in, so pops never overrun mem.
   assign credit  = DEPTH - occ - inflight;
   assign rinc    = ~rempty & ~rrst & (credit != '0);
   assign cap     = vld_pipe[RD_LAT-1];
   assign m_valid = (occ != '0);
   assign hs      = m_valid & m_ready;
   assign m_data  = mem[rptr];

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         vld_pipe <= '0;
         wptr     <= '0;
         rptr     <= '0;
         occ      <= '0;
         rcount   <= '0;
      end else begin
         vld_pipe <= RD_LAT'({vld_pipe, rinc});
         if (cap) wptr <= wptr + 1'b1;
         if (hs) begin
            rptr   <= rptr + 1'b1;
            rcount <= rcount + 16'd1;
         end
         occ <= occ + CW'(cap) - CW'(hs);
      end
   end

   always_ff @(posedge rclk) begin
      if (cap) mem[wptr] <= rdata;
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with read latency feeding the DUT,
// scoreboard of popped words checked at each stream handshake.
module tb_fifo_rd_stream;

   localparam int DSIZE  = 8;
   localparam int RD_LAT = 2;
   localparam int BDEPTH = 4;

   logic             rclk = 1'b0;
   logic             rrst, rempty, rinc, m_valid, m_ready;
   logic [DSIZE-1:0] rdata, m_data;
   logic [15:0]      rcount;

   fifo_rd_stream #(.DSIZE(DSIZE), .RD_LAT(RD_LAT), .BDEPTH(BDEPTH)) dut (
      .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rcount(rcount)
   );

   always #5 rclk = ~rclk;

   typedef struct { int due; logic [DSIZE-1:0] d; } pend_t;

   logic [DSIZE-1:0] src_q[$];
   logic [DSIZE-1:0] exp_q[$];
   pend_t            pend_q[$];
   int               pop_cyc_q[$];
   int               hs_cyc_q[$];
   int               cyc, n_chk, n_err, occ_m, outst, pop_cnt, hs_cnt, p0;
   bit               cap_now, force_empty, prev_stall;
   logic [DSIZE-1:0] prev_data, wseq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_model();
      src_q.delete(); exp_q.delete(); pend_q.delete();
      occ_m = 0; outst = 0; hs_cnt = 0; prev_stall = 0;
   endtask

   // One rclk cycle: drive FIFO side, check at negedge, update model, step past edge.
   task automatic cycle();
      logic [DSIZE-1:0] w;
      rempty  = (src_q.size() == 0) || force_empty;
      cap_now = 0;
      rdata   = DSIZE'($urandom);
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
         rdata   = pend_q[0].d;
         cap_now = 1;
         pend_q.delete(0);
      end
      @(negedge rclk);
      if (rrst) begin
         chk("rst_rinc", 32'(rinc), 32'd0);
         chk("rst_valid", 32'(m_valid), 32'd0);
      end else begin
         chk("rinc", 32'(rinc), 32'(!rempty && outst < BDEPTH));
         chk("m_valid", 32'(m_valid), 32'(occ_m != 0));
         if (prev_stall) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            chk("word_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("data", 32'(m_data), 32'(exp_q.pop_front()));
            hs_cnt++;
            hs_cyc_q.push_back(cyc);
            if (occ_m > 0) occ_m--;
            if (outst > 0) outst--;
         end
         if (rinc && !rempty && src_q.size() > 0) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
            pend_q.push_back('{cyc + RD_LAT, w});
            outst++;
            pop_cnt++;
            pop_cyc_q.push_back(cyc);
         end
         if (cap_now) occ_m++;
         chk("bound", 32'(outst <= BDEPTH), 32'd1);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
      @(posedge rclk);
      #1;
      cyc++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected simulation to complete");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0; cyc = 0; pop_cnt = 0; wseq = '0;
      force_empty = 0; prev_data = '0;
      clear_model();
      rrst = 1'b1; rempty = 1'b1; rdata = '0; m_ready = 1'b0;
      repeat (2) @(posedge rclk);
      #1;
      chk("reset_rinc", 32'(rinc), 32'd0);
      chk("reset_valid", 32'(m_valid), 32'd0);
      chk("reset_rcount", 32'(rcount), 32'd0);
      rrst = 1'b0;
      repeat (2) cycle();

      // single word, fixed latency
      pop_cyc_q.delete(); hs_cyc_q.delete();
      m_ready = 1'b1;
      src_q.push_back(8'hA5);
      repeat (8) cycle();
      chk("t1_pops", 32'(pop_cyc_q.size()), 32'd1);
      chk("t1_hs", 32'(hs_cyc_q.size()), 32'd1);
      if (pop_cyc_q.size() > 0 && hs_cyc_q.size() > 0)
         chk("t1_latency", 32'(hs_cyc_q[0] - pop_cyc_q[0]), 32'(RD_LAT + 1));
      chk("t1_rcount", 32'(rcount), 32'd1);

      // streaming, one word per cycle
      pop_cyc_q.delete(); hs_cyc_q.delete();
      for (int i = 0; i < 32; i++) src_q.push_back(DSIZE'(i));
      repeat (40) cycle();
      chk("t2_pops", 32'(pop_cyc_q.size()), 32'd32);
      chk("t2_hs", 32'(hs_cyc_q.size()), 32'd32);
      if (pop_cyc_q.size() == 32 && hs_cyc_q.size() == 32) begin
         chk("t2_pop_span", 32'(pop_cyc_q[31] - pop_cyc_q[0]), 32'd31);
         chk("t2_hs_span", 32'(hs_cyc_q[31] - hs_cyc_q[0]), 32'd31);
         chk("t2_latency", 32'(hs_cyc_q[0] - pop_cyc_q[0]), 32'(RD_LAT + 1));
      end
      chk("t2_rcount", 32'(rcount), 32'd33);

      // backpressure
      pop_cyc_q.delete(); hs_cyc_q.delete();
      m_ready = 1'b0;
      p0 = pop_cnt;
      for (int i = 0; i < 10; i++) src_q.push_back(DSIZE'(8'h40 + i));
      repeat (8) cycle();
      chk("t3_pops", 32'(pop_cnt - p0), 32'(BDEPTH));
      chk("t3_valid", 32'(m_valid), 32'd1);
      chk("t3_data", 32'(m_data), 32'h40);
      chk("t3_rinc", 32'(rinc), 32'd0);
      m_ready = 1'b1;
      repeat (20) cycle();
      chk("t3_hs", 32'(hs_cyc_q.size()), 32'd10);

      // FIFO runs dry mid-stream
      pop_cyc_q.delete(); hs_cyc_q.delete();
      for (int i = 0; i < 3; i++) src_q.push_back(DSIZE'(8'h60 + i));
      repeat (10) cycle();
      chk("t4_pops", 32'(pop_cyc_q.size()), 32'd3);
      chk("t4_hs", 32'(hs_cyc_q.size()), 32'd3);
      chk("t4_valid", 32'(m_valid), 32'd0);

      // reset with two words buffered and two in flight
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) src_q.push_back(DSIZE'(8'h70 + i));
      repeat (4) cycle();
      chk("t5_pre_valid", 32'(m_valid), 32'd1);
      #2 rrst = 1'b1;
      #1;
      chk("t5_async_rinc", 32'(rinc), 32'd0);
      chk("t5_async_valid", 32'(m_valid), 32'd0);
      chk("t5_async_rcount", 32'(rcount), 32'd0);
      clear_model();
      repeat (2) cycle();
      rrst = 1'b0;
      cycle();
      pop_cyc_q.delete(); hs_cyc_q.delete();
      for (int i = 0; i < 6; i++) src_q.push_back(DSIZE'(8'h80 + i));
      m_ready = 1'b1;
      repeat (15) cycle();
      chk("t5_hs", 32'(hs_cyc_q.size()), 32'd6);
      chk("t5_rcount", 32'(rcount), 32'd6);

      // random rempty / m_ready
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            src_q.push_back(wseq);
            wseq = wseq + 1'b1;
         end
         force_empty = ($urandom_range(0, 3) == 0);
         m_ready     = ($urandom_range(0, 2) != 0);
         cycle();
      end
      force_empty = 0;
      m_ready     = 1'b1;
      for (int n = 0; n < 1000 && (src_q.size() > 0 || exp_q.size() > 0); n++) cycle();
      chk("t6_drained", 32'(exp_q.size()), 32'd0);
      chk("t6_rcount", 32'(rcount), 32'(hs_cnt[15:0]));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
